apb_master: RTL and testbench

//  Bridges a simple valid/ready command port onto an APB3 bus (4-bit address, 8-bit data).

---
 rtl/apb_master_if.sv | 42 ++++
 rtl/apb_master.sv | 154 +++++++++++++++
 tb/tb_apb_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// -----------------------------------------------------------------------------
// apb_master_if
//   Bundles the command/response port and the APB3 bus of apb_master.
//   The "master" modport is the view of the bridge itself; the "slave" modport
//   is the view of whatever sits around it (command source + APB peripheral).
//
//   Command side : cmd_valid, cmd_ready, cmd_write, cmd_addr[3:0], cmd_wdata[7:0]
//   Response side: rsp_valid, rsp_err, rsp_rdata[7:0]
//   APB side     : paddr[3:0], pwrite, psel, penable, pwdata[7:0],
//                  prdata[7:0], pready
// -----------------------------------------------------------------------------
interface apb_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;

   logic       rsp_valid;
   logic       rsp_err;
   logic [7:0] rsp_rdata;

   logic [3:0] paddr;
   logic       pwrite;
   logic       psel;
   logic       penable;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
      output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
             paddr, pwrite, psel, penable, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
      input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
             paddr, pwrite, psel, penable, pwdata
   );
endinterface

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   Bridges a valid/ready command port onto an APB3 bus (4-bit address,
//   8-bit data). One transfer in flight at a time; each transfer ends with a
//   one-cycle response pulse carrying read data or a timeout error.
//
//   Parameters
//     TIMEOUT : max ACCESS cycles with pready low before abort (0 = never)
//     CW      : wait counter width, 2**CW must exceed TIMEOUT
//
//   Ports
//     pclk  : bus clock, everything on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : apb_master_if.master (command, response and APB signals)
//
//   All bus and response outputs come straight from flops.
// -----------------------------------------------------------------------------
module apb_master #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input logic          pclk,
   input logic          rst_n,
   apb_master_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [CW-1:0] WAIT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] TIMEOUT_W = CW'(TIMEOUT);
   localparam bit            TO_EN     = (TIMEOUT != 0);

   state_t        state_q,     state_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          psel_q,      psel_d;
   logic          penable_q,   penable_d;
   logic          pwrite_q,    pwrite_d;
   logic [3:0]    paddr_q,     paddr_d;
   logic [7:0]    pwdata_q,    pwdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q,   rsp_err_d;
   logic [7:0]    rsp_rdata_q, rsp_rdata_d;
   logic [CW-1:0] wait_q,      wait_d;

   logic [CW-1:0] wait_inc;
   logic          timeout_hit;

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      wait_d      = wait_q;
      // Response fields are only meaningful for the single DONE cycle.
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 8'h00;

      // Saturating increment: a long stall with TIMEOUT=0 must not wrap.
      wait_inc    = (wait_q == WAIT_MAX) ? wait_q : wait_q + CW'(1);
      timeout_hit = TO_EN && (wait_inc >= TIMEOUT_W);

      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               paddr_d  = bus.cmd_addr;
               pwrite_d = bus.cmd_write;
               pwdata_d = bus.cmd_wdata;
               psel_d   = 1'b1;
               wait_d   = '0;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            // pready is checked first so a completion on the very edge the
            // counter would reach TIMEOUT is a normal completion.
            if (bus.pready) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? 8'h00 : bus.prdata;
               state_d     = ST_DONE;
            end else begin
               wait_d = wait_inc;
               if (timeout_hit) begin
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  state_d     = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= 4'h0;
         pwdata_q    <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 8'h00;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_q      <= wait_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//   Self-checking bench for apb_master. A transaction-level model predicts,
//   for each command and a chosen number of slave wait states, how long the
//   ACCESS phase lasts, whether the transfer times out and what the response
//   carries. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_master;

   localparam int TO = 4;
   localparam int CW = 3;

   typedef struct {
      bit       w;
      bit [3:0] a;
      bit [7:0] d;
      int       waits;   // ACCESS cycles the slave holds pready low
      bit [7:0] sd;      // data the slave returns for a read
   } cmd_t;

   logic pclk;
   logic rst_n;
   int   edge_n     = 0;
   int   checks     = 0;
   int   errors     = 0;
   int   rsp_seen   = 0;
   int   exp_pulses = 0;
   logic psel_prev  = 1'b0;
   logic rsp_prev   = 1'b0;
   cmd_t cq[$];

   apb_master_if bus();

   apb_master #(.TIMEOUT(TO), .CW(CW)) dut (
      .pclk  (pclk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(posedge pclk) edge_n <= edge_n + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Bus-level rules that must hold on every cycle, plus response pulse count.
   always @(negedge pclk) begin
      if (rst_n) begin
         check_eq("apb_proto",
                  32'({bus.penable & ~bus.psel, bus.psel & ~psel_prev & bus.penable,
                       bus.rsp_valid & rsp_prev}), 32'h0);
         if (bus.rsp_valid) rsp_seen++;
      end
      psel_prev <= bus.psel;
      rsp_prev  <= bus.rsp_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic cmd_t mk(input bit w, input bit [3:0] a, input bit [7:0] d,
                               input int waits, input bit [7:0] sd);
      cmd_t c;
      c.w = w; c.a = a; c.d = d; c.waits = waits; c.sd = sd;
      return c;
   endfunction

   function automatic int rand_waits();
      case ($urandom_range(0, 5))
         0:       return 0;
         1:       return 1;
         2:       return 2;
         3:       return TO - 1;
         4:       return TO;
         default: return TO + 2;
      endcase
   endfunction

   task automatic drive_cmd(input cmd_t c);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = c.w;
      bus.cmd_addr  = c.a;
      bus.cmd_wdata = c.d;
   endtask

   task automatic drive_idle();
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 4'($urandom);
      bus.cmd_wdata = 8'($urandom);
   endtask

   // Runs every queued command; with b2b the next command is presented as
   // soon as the current one is accepted. Starts and ends on an idle cycle.
   task automatic run_queue(input bit b2b);
      int       acc, prev_acc, prev_len, len, n;
      bit       exp_err;
      bit [7:0] exp_rd;
      cmd_t     c;
      prev_acc = 0;
      prev_len = 0;
      for (int i = 0; i < cq.size(); i++) begin
         c       = cq[i];
         exp_err = (TO != 0) && (c.waits >= TO);
         len     = exp_err ? TO : c.waits + 1;
         exp_rd  = (!exp_err && !c.w) ? c.sd : 8'h00;
         drive_cmd(c);
         n = 0;
         while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge pclk);
            n++;
         end
         if (bus.cmd_ready !== 1'b1) begin
            check_eq("accept_wait", 32'(bus.cmd_ready), 32'h1);
            cq.delete();
            return;
         end
         acc = edge_n + 1;
         if (b2b && i > 0) check_eq("b2b_spacing", acc - prev_acc, prev_len + 3);

         @(negedge pclk);
         if (b2b && i + 1 < cq.size()) drive_cmd(cq[i + 1]);
         else drive_idle();
         bus.pready = 1'($urandom);
         bus.prdata = 8'($urandom);
         check_eq("setup_sel_en", 32'({bus.psel, bus.penable}), 32'h2);
         check_eq("setup_bus", 32'({bus.paddr, bus.pwrite, bus.pwdata}), 32'({c.a, c.w, c.d}));
         check_eq("setup_busy", 32'({bus.cmd_ready, bus.rsp_valid}), 32'h0);

         for (int k = 0; k < len; k++) begin
            @(negedge pclk);
            check_eq("access_sel_en", 32'({bus.psel, bus.penable}), 32'h3);
            check_eq("access_bus", 32'({bus.paddr, bus.pwrite, bus.pwdata}), 32'({c.a, c.w, c.d}));
            check_eq("access_busy", 32'({bus.cmd_ready, bus.rsp_valid}), 32'h0);
            bus.pready = (k == c.waits);
            bus.prdata = bus.pready ? c.sd : 8'($urandom);
         end

         @(negedge pclk);
         bus.pready = 1'($urandom);
         bus.prdata = 8'($urandom);
         exp_pulses++;
         check_eq("done_sel_en", 32'({bus.psel, bus.penable}), 32'h0);
         check_eq("done_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}),
                  32'({1'b1, exp_err, exp_rd}));
         check_eq("done_hold", 32'({bus.paddr, bus.pwrite, bus.pwdata}), 32'({c.a, c.w, c.d}));
         check_eq("done_ready", 32'(bus.cmd_ready), 32'h0);
         prev_acc = acc;
         prev_len = len;

         if (!b2b || i + 1 == cq.size()) begin
            drive_idle();
            @(negedge pclk);
            check_eq("idle_state", 32'({bus.cmd_ready, bus.psel, bus.penable, bus.rsp_valid}), 32'h8);
            check_eq("idle_hold", 32'({bus.paddr, bus.pwrite, bus.pwdata}), 32'({c.a, c.w, c.d}));
            repeat ($urandom_range(0, 2)) @(negedge pclk);
         end
      end
      cq.delete();
   endtask

   task automatic reset_mid_access();
      int base;
      drive_cmd(mk(1'b0, 4'hE, 8'h00, 3, 8'h00));
      bus.pready = 1'b0;
      check_eq("rst_pre_ready", 32'(bus.cmd_ready), 32'h1);
      @(negedge pclk);
      drive_idle();
      bus.pready = 1'b0;
      @(negedge pclk);
      check_eq("rst_pre_access", 32'({bus.psel, bus.penable}), 32'h3);
      base = rsp_seen;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_async_sel", 32'({bus.psel, bus.penable}), 32'h0);
      check_eq("rst_async_bus", 32'({bus.paddr, bus.pwrite, bus.pwdata, bus.cmd_ready}),
               32'({4'h0, 1'b0, 8'h00, 1'b1}));
      @(negedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
      bus.pready = 1'b1;
      repeat (4) @(negedge pclk);
      check_eq("rst_no_rsp", rsp_seen - base, 0);
      check_eq("rst_idle", 32'({bus.psel, bus.penable, bus.cmd_ready}), 32'h1);
   endtask

   initial begin
      int base;
      rst_n      = 1'b0;
      bus.pready = 1'b0;
      bus.prdata = 8'h00;
      drive_idle();
      repeat (3) @(negedge pclk);
      check_eq("reset_ready", 32'(bus.cmd_ready), 32'h1);
      check_eq("reset_apb", 32'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 32'h0);
      check_eq("reset_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 32'h0);
      rst_n = 1'b1;
      @(negedge pclk);

      // Zero-wait write, then a read with two wait states.
      cq.push_back(mk(1'b1, 4'd3, 8'hA5, 0, 8'h00));
      run_queue(1'b0);
      cq.push_back(mk(1'b0, 4'd7, 8'h00, 2, 8'h55));
      run_queue(1'b0);

      // Four back-to-back commands with cmd_valid held high.
      base = rsp_seen;
      for (int i = 0; i < 4; i++)
         cq.push_back(mk(1'($urandom), 4'($urandom), 8'($urandom), 0, 8'($urandom)));
      run_queue(1'b1);
      check_eq("b2b_pulses", rsp_seen - base, 4);

      // Timeout abort followed by a normal command.
      cq.push_back(mk(1'b0, 4'd5, 8'h11, TO, 8'hEE));
      cq.push_back(mk(1'b0, 4'd6, 8'h22, 1, 8'h3C));
      run_queue(1'b0);

      // pready arrives on the edge the counter would reach TIMEOUT.
      cq.push_back(mk(1'b0, 4'd9, 8'h00, TO - 1, 8'hC3));
      run_queue(1'b0);

      // Reset in ACCESS, then a read afterwards.
      reset_mid_access();
      cq.push_back(mk(1'b0, 4'd2, 8'h00, 1, 8'h9A));
      run_queue(1'b0);

      // Random batches.
      for (int b = 0; b < 14; b++) begin
         int n;
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++)
            cq.push_back(mk(1'($urandom), 4'($urandom), 8'($urandom), rand_waits(), 8'($urandom)));
         run_queue(1'($urandom));
      end

      @(negedge pclk);
      #1;
      check_eq("rsp_pulses", rsp_seen, exp_pulses);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
